change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Payout side of the vending machine. The purchase logic accepts coins and computes `balance`; this block receives that balance as a change request and pays it out coin by coin from three coin tubes (values 5, 2, 1).
- Drives coin-ejector solenoids with timed pulses and tracks each tube's inventory.
- Reports any amount it could not pay.

Parameters:
PULSE_CYC, 2, cycles each coin_out line stays high per coin (legal 1..15)
GAP_CYC, 1, cycles all coin_out lines stay low between coins (legal 1..15)
TUBE_MAX, 15, maximum coin count per tube (fits 4 bits)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  change request strobe; sampled only in IDLE
amount  input  4  change value to pay (0..15), sampled with req
refill  input  3  one-hot tube select {5,2,1} = bits {2,1,0}; all-zero = no refill
refill_cnt  input  4  coins added to the selected tube
busy  output  1  high from the cycle after req acceptance until done
done  output  1  one-cycle pulse when the payout finishes
short  output  4  unpaid remainder, valid from the done pulse until next acceptance
coin_out  output  3  one-hot ejector drive {5,2,1}
cnt5, cnt2, cnt1  output  4 each  current tube inventories

Behaviour:
- Reset values (asserted asynchronously): busy=0, done=0, short=0, coin_out=0, cnt5=cnt2=cnt1=0, state=IDLE, remaining=0.
- Reset asserted mid-payout: ejector drops immediately and the transaction is lost. No done pulse is produced.
- States are IDLE, SELECT, PULSE, GAP, DONE.
- IDLE, request:
  - If req=1: latch remaining=amount, clear short, go to SELECT.
  - busy=1 from the next cycle.
- IDLE, refill:
  - If refill is non-zero, the selected tube count becomes min(count+refill_cnt, TUBE_MAX), saturating.
  - The addition is done 5 bits wide.
  - Refill and req in the same cycle: both are accepted, and SELECT sees the refilled count.
- Illegal refill values:
  - A refill that is not one-hot is ignored.
  - A refill outside IDLE is ignored.
- req outside IDLE is ignored.
- SELECT takes one cycle and applies greedy largest-first selection:
  - remaining=0 → go to DONE with short=0.
  - Else pick the largest d in {5,2,1} with d≤remaining and tube count>0, then go to PULSE.
  - That same cycle: decrement the tube count and set remaining-=d.
  - No coin eligible → go to DONE with short=remaining.
  - Greedy is the decided algorithm; no backtracking. Example: amount 6 with tubes 5:1, 2:3, 1:0 → pays 5, then short=1.
- PULSE: the one-hot coin_out bit for d is high for exactly PULSE_CYC cycles, registered, no glitches. Then go to GAP.
- GAP: coin_out=0 for exactly GAP_CYC cycles, then go to SELECT.
- DONE: done=1 for one cycle, busy=0 in that same cycle, then go to IDLE.
  - A req in the DONE cycle is ignored.
- Latency per coin = 1 + PULSE_CYC + GAP_CYC cycles.
- Total latency = coins × (1+PULSE_CYC+GAP_CYC) + 1 (final SELECT) + 1 (DONE).
- Counts never underflow and never exceed TUBE_MAX.

Decomposition:
- shop_pkg holds:
  - state encoding localparams: IDLE, SELECT, PULSE, GAP, DONE;
  - denomination constants: DENOM5=5, DENOM2=2, DENOM1=1;
  - one-hot index constants: IDX5=2, IDX2=1, IDX1=0.
- Sub-module coin_tube, instantiated three times:
  - 4-bit inventory with saturating load-add (TUBE_MAX) and decrement.
  - Outputs the count and a nonzero flag.
- The top level holds the FSM, the remaining register, the shared pulse/gap down-counter and the selector.

Test Plan:
- Refill 5:2, 2:2, 1:2; req amount=8:
  - coin_out pulses 100, 010, 001, each 2 cycles with 1-cycle gaps.
  - done 14 cycles after the req edge; short=0; counts 1,1,1.
- Tubes 5:0, 2:0, 1:3; amount=5 → three 1-coin pulses, then done with short=2 and cnt1=0.
- Greedy case: tubes 5:1, 2:3, 1:0; amount=6 → one 5-coin pulse, done with short=1, cnt2 stays 3.
- amount=0 → no coin_out activity; done 2 cycles after req; short=0.
- Tube 1 count 12 + refill_cnt=9 → cnt1 saturates at 15.
  - Refill and req(amount=1) in the same cycle with cnt1 previously 0 → one 1-coin pulse, short=0.
- Robustness:
  - Assert reset during the 2nd cycle of a PULSE → coin_out=0 in the same cycle, all counts 0, no done.
  - req during busy is ignored.

Source files
------------

// File: rtl/shop_pkg.sv
// Shared definitions for the change dispenser: FSM states, coin values, tube indices.
// No logic of its own; helper functions are pure combinational.
// Nothing here applies backpressure.
package shop_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DENOM5 = 5;
  localparam int DENOM2 = 2;
  localparam int DENOM1 = 1;

  localparam int IDX5 = 2;
  localparam int IDX2 = 1;
  localparam int IDX1 = 0;

  // True when exactly one tube is selected.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

  // Coin value of a one-hot tube select; zero when nothing is selected.
  function automatic logic [3:0] denom_of(input logic [2:0] oh);
    logic [3:0] d;
    d = 4'd0;
    if (oh[IDX5])      d = 4'(DENOM5);
    else if (oh[IDX2]) d = 4'(DENOM2);
    else if (oh[IDX1]) d = 4'(DENOM1);
    return d;
  endfunction

endpackage

// File: rtl/coin_tube.sv
// One coin tube inventory: saturating refill add and single-coin take.
// Count updates one cycle after load/take.
// No backpressure; a take on an empty tube is dropped.
module coin_tube #(
  parameter int TUBE_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] add,
  input  logic       take,
  output logic [3:0] cnt,
  output logic       nonzero
);

  // Sum is formed one bit wider so a refill can never wrap before saturation.
  logic [4:0] sum;
  assign sum     = {1'b0, cnt} + {1'b0, add};
  assign nonzero = (cnt != 4'd0);

  // Inventory register: refill saturates at TUBE_MAX, take never underflows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= (sum > 5'(TUBE_MAX)) ? 4'(TUBE_MAX) : sum[3:0];
    end else if (take && nonzero) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount greedily from 5/2/1 tubes with timed ejector pulses.
// Per coin 1+PULSE_CYC+GAP_CYC cycles, plus one final SELECT and one DONE cycle.
// Requests and refills are only taken in IDLE; anything arriving while busy is dropped.
module change_dispenser
  import shop_pkg::*;
#(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int TUBE_MAX  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] amount,
  input  logic [2:0] refill,
  input  logic [3:0] refill_cnt,
  output logic       busy,
  output logic       done,
  output logic [3:0] short,
  output logic [2:0] coin_out,
  output logic [3:0] cnt5,
  output logic [3:0] cnt2,
  output logic [3:0] cnt1
);

  state_t           state, state_nxt;
  logic [3:0]       remaining, remaining_nxt;
  logic [3:0]       short_nxt;
  logic [3:0]       tmr, tmr_nxt;
  logic [2:0]       coin_nxt;
  logic [2:0]       take;
  logic [2:0]       nonzero;
  logic [2:0]       elig;
  logic [2:0]       pick;
  logic             refill_ok;
  logic [2:0][3:0]  tube_cnt;

  assign refill_ok = (state == IDLE) && is_onehot3(refill);

  for (genvar i = 0; i < 3; i++) begin : g_tube
    coin_tube #(.TUBE_MAX(TUBE_MAX)) u_tube (
      .clk     (clk),
      .reset   (reset),
      .load    (refill_ok & refill[i]),
      .add     (refill_cnt),
      .take    (take[i]),
      .cnt     (tube_cnt[i]),
      .nonzero (nonzero[i])
    );
  end

  assign cnt5 = tube_cnt[IDX5];
  assign cnt2 = tube_cnt[IDX2];
  assign cnt1 = tube_cnt[IDX1];

  assign busy = (state == SELECT) || (state == PULSE) || (state == GAP);
  assign done = (state == DONE);

  // Greedy selector: largest coin that fits the remainder and is in stock.
  always_comb begin
    elig       = 3'b000;
    elig[IDX5] = (remaining >= 4'(DENOM5)) && nonzero[IDX5];
    elig[IDX2] = (remaining >= 4'(DENOM2)) && nonzero[IDX2];
    elig[IDX1] = (remaining >= 4'(DENOM1)) && nonzero[IDX1];
    pick = 3'b000;
    if (elig[IDX5])      pick[IDX5] = 1'b1;
    else if (elig[IDX2]) pick[IDX2] = 1'b1;
    else if (elig[IDX1]) pick[IDX1] = 1'b1;
  end

  // Next-state logic; coin_out is computed here and registered so the ejector never glitches.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    short_nxt     = short;
    tmr_nxt       = tmr;
    coin_nxt      = coin_out;
    take          = 3'b000;
    case (state)
      IDLE: begin
        if (req) begin
          remaining_nxt = amount;
          short_nxt     = 4'd0;
          state_nxt     = SELECT;
        end
      end
      SELECT: begin
        if (remaining == 4'd0) begin
          short_nxt = 4'd0;
          state_nxt = DONE;
        end else if (pick != 3'b000) begin
          take          = pick;
          remaining_nxt = remaining - denom_of(pick);
          coin_nxt      = pick;
          tmr_nxt       = 4'(PULSE_CYC - 1);
          state_nxt     = PULSE;
        end else begin
          short_nxt = remaining;
          state_nxt = DONE;
        end
      end
      PULSE: begin
        if (tmr == 4'd0) begin
          coin_nxt  = 3'b000;
          tmr_nxt   = 4'(GAP_CYC - 1);
          state_nxt = GAP;
        end else begin
          tmr_nxt = tmr - 4'd1;
        end
      end
      GAP: begin
        if (tmr == 4'd0) begin
          state_nxt = SELECT;
        end else begin
          tmr_nxt = tmr - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        coin_nxt  = 3'b000;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, remainder, shortfall, shared pulse/gap timer and ejector drive registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= 4'd0;
      short     <= 4'd0;
      tmr       <= 4'd0;
      coin_out  <= 3'b000;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      short     <= short_nxt;
      tmr       <= tmr_nxt;
      coin_out  <= coin_nxt;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table rows, hand corner cases, random vs model.
// Inputs are driven and outputs sampled on the falling edge.
// Every DUT wait is bounded by a cycle budget.
module tb_change_dispenser;

  localparam int PC = 2;
  localparam int GC = 1;
  localparam int PER_COIN = 1 + PC + GC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [3:0] amount = 4'd0;
  logic [2:0] refill = 3'b000;
  logic [3:0] refill_cnt = 4'd0;
  logic       busy, done;
  logic [3:0] short;
  logic [2:0] coin_out;
  logic [3:0] cnt5, cnt2, cnt1;

  change_dispenser #(.PULSE_CYC(PC), .GAP_CYC(GC), .TUBE_MAX(15)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req        (req),
    .amount     (amount),
    .refill     (refill),
    .refill_cnt (refill_cnt),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .coin_out   (coin_out),
    .cnt5       (cnt5),
    .cnt2       (cnt2),
    .cnt1       (cnt1)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: tube counts indexed 0:1-coin, 1:2-coin, 2:5-coin.
  int         m_cnt[3];
  int         den[3] = '{1, 2, 5};
  logic [2:0] exp_coins[$];
  int         exp_short;

  // Observations of one transaction.
  logic [2:0] obs_coin[$];
  int         obs_start[$];
  int         obs_len[$];
  int         obs_lat;
  logic       obs_busy0, obs_busy_done, obs_busy_drop;
  logic [3:0] obs_short0, obs_short_done;

  typedef struct {
    int c5, c2, c1, amt, n, sh, f5, f2, f1;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic model_refill(input logic [2:0] rf, input int rc);
    int k;
    if ($countones(rf) == 1) begin
      k = rf[2] ? 2 : (rf[1] ? 1 : 0);
      m_cnt[k] = (m_cnt[k] + rc > 15) ? 15 : m_cnt[k] + rc;
    end
  endtask

  task automatic model_pay(input int amt);
    int  rem;
    bit  found;
    exp_coins.delete();
    rem = amt;
    while (rem > 0) begin
      found = 0;
      for (int i = 2; i >= 0; i--) begin
        if (!found && den[i] <= rem && m_cnt[i] > 0) begin
          found = 1;
          m_cnt[i]--;
          rem -= den[i];
          exp_coins.push_back(3'(1 << i));
        end
      end
      if (!found) break;
    end
    exp_short = rem;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0; refill = 3'b000; refill_cnt = 4'd0; amount = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_refill(input logic [2:0] rf, input logic [3:0] rc);
    refill = rf; refill_cnt = rc;
    @(negedge clk);
    refill = 3'b000; refill_cnt = 4'd0;
  endtask

  // Issue one request and record pulses until done (bounded); poke>=0 injects a req+refill mid-payout.
  task automatic pay(input logic [3:0] amt, input logic [2:0] rf, input logic [3:0] rc, input int poke);
    int         idx;
    bit         seen;
    logic [2:0] prev;
    obs_coin.delete(); obs_start.delete(); obs_len.delete();
    obs_lat = -1; obs_busy_drop = 1'b0; obs_busy_done = 1'b1; obs_short_done = 4'hF;
    req = 1'b1; amount = amt; refill = rf; refill_cnt = rc;
    @(negedge clk);
    req = 1'b0; refill = 3'b000; refill_cnt = 4'd0;
    obs_busy0 = busy; obs_short0 = short;
    idx = 0; seen = 0; prev = 3'b000;
    while (!seen && idx < 400) begin
      if (coin_out != 3'b000) begin
        if (coin_out != prev) begin
          obs_coin.push_back(coin_out); obs_start.push_back(idx); obs_len.push_back(1);
        end else begin
          obs_len[obs_len.size()-1] += 1;
        end
      end
      if (done) begin
        seen = 1; obs_lat = idx + 1; obs_busy_done = busy; obs_short_done = short;
      end else begin
        if (!busy) obs_busy_drop = 1'b1;
        if (idx == poke) begin
          req = 1'b1; amount = 4'd3; refill = 3'b001; refill_cnt = 4'd4;
        end else if (idx == poke + 1) begin
          req = 1'b0; refill = 3'b000; refill_cnt = 4'd0;
        end
        prev = coin_out;
        idx++;
        @(negedge clk);
      end
    end
    req = 1'b0; refill = 3'b000; refill_cnt = 4'd0;
  endtask

  task automatic verify(input string tag, input int n, input int sh, input int c5, input int c2, input int c1);
    check({tag, " latency"}, obs_lat, n * PER_COIN + 2);
    check({tag, " pulses"}, obs_coin.size(), n);
    for (int j = 0; j < obs_coin.size() && j < exp_coins.size(); j++) begin
      check({tag, " coin"}, int'(obs_coin[j]), int'(exp_coins[j]));
      check({tag, " pulse_start"}, obs_start[j], 1 + j * PER_COIN);
      check({tag, " pulse_len"}, obs_len[j], PC);
    end
    check({tag, " busy_first"}, int'(obs_busy0), 1);
    check({tag, " short_clear"}, int'(obs_short0), 0);
    check({tag, " busy_at_done"}, int'(obs_busy_done), 0);
    check({tag, " busy_gap"}, int'(obs_busy_drop), 0);
    check({tag, " short"}, int'(obs_short_done), sh);
    check({tag, " cnt5"}, int'(cnt5), c5);
    check({tag, " cnt2"}, int'(cnt2), c2);
    check({tag, " cnt1"}, int'(cnt1), c1);
  endtask

  initial begin
    int dcount;
    int amt, rc, rf;

    tbl[0] = '{2, 2, 2, 8, 3, 0, 1, 1, 1};
    tbl[1] = '{0, 0, 3, 5, 3, 2, 0, 0, 0};
    tbl[2] = '{1, 3, 0, 6, 1, 1, 0, 3, 0};
    tbl[3] = '{2, 2, 2, 0, 0, 0, 2, 2, 2};
    tbl[4] = '{3, 0, 0, 15, 3, 0, 0, 0, 0};
    tbl[5] = '{0, 7, 1, 15, 8, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 9, 0, 9, 0, 0, 0};
    tbl[7] = '{1, 1, 1, 4, 2, 1, 1, 0, 0};

    // Reset state.
    do_reset();
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst short", int'(short), 0);
    check("rst coin_out", int'(coin_out), 0);
    check("rst cnt5", int'(cnt5), 0);
    check("rst cnt2", int'(cnt2), 0);
    check("rst cnt1", int'(cnt1), 0);

    // Table-driven payouts.
    for (int r = 0; r < 8; r++) begin
      do_reset(); model_reset();
      do_refill(3'b100, 4'(tbl[r].c5)); model_refill(3'b100, tbl[r].c5);
      do_refill(3'b010, 4'(tbl[r].c2)); model_refill(3'b010, tbl[r].c2);
      do_refill(3'b001, 4'(tbl[r].c1)); model_refill(3'b001, tbl[r].c1);
      model_pay(tbl[r].amt);
      pay(4'(tbl[r].amt), 3'b000, 4'd0, -1);
      verify($sformatf("row%0d", r), tbl[r].n, tbl[r].sh, tbl[r].f5, tbl[r].f2, tbl[r].f1);
      @(negedge clk);
      check($sformatf("row%0d short_hold", r), int'(short), tbl[r].sh);
    end

    // Saturating refill.
    do_reset();
    do_refill(3'b001, 4'd12);
    check("sat pre", int'(cnt1), 12);
    do_refill(3'b001, 4'd9);
    check("sat cnt1", int'(cnt1), 15);

    // Non-one-hot refills are ignored.
    do_reset();
    do_refill(3'b011, 4'd5);
    do_refill(3'b111, 4'd4);
    check("illegal cnt5", int'(cnt5), 0);
    check("illegal cnt2", int'(cnt2), 0);
    check("illegal cnt1", int'(cnt1), 0);

    // Refill and request in the same cycle: SELECT sees the refilled tube.
    do_reset(); model_reset();
    model_refill(3'b001, 1); model_pay(1);
    pay(4'd1, 3'b001, 4'd1, -1);
    verify("same_cycle", 1, 0, 0, 0, 0);

    // req and refill while busy are ignored; req in the DONE cycle is ignored.
    do_reset(); model_reset();
    do_refill(3'b100, 4'd3); model_refill(3'b100, 3);
    do_refill(3'b001, 4'd3); model_refill(3'b001, 3);
    model_pay(5);
    pay(4'd5, 3'b000, 4'd0, 2);
    verify("busy_ignore", 1, 0, 2, 0, 3);
    req = 1'b1; amount = 4'd1;
    @(negedge clk);
    req = 1'b0;
    check("done_req busy", int'(busy), 0);
    @(negedge clk);
    check("done_req busy2", int'(busy), 0);
    check("done_req cnt1", int'(cnt1), 3);

    // Reset asserted in the second PULSE cycle.
    do_reset();
    do_refill(3'b100, 4'd2);
    req = 1'b1; amount = 4'd5;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst pulse_on", int'(coin_out), 4);
    rst_n = 1'b0;
    #1;
    check("midrst coin_out", int'(coin_out), 0);
    check("midrst cnt5", int'(cnt5), 0);
    check("midrst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy || coin_out != 3'b000) dcount++;
    end
    check("midrst no_done", dcount, 0);

    // Randomized transactions against the model.
    do_reset(); model_reset();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        rf = $urandom_range(0, 7); rc = $urandom_range(0, 15);
        do_refill(3'(rf), 4'(rc)); model_refill(3'(rf), rc);
      end
      amt = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        rf = $urandom_range(0, 7); rc = $urandom_range(0, 15);
      end else begin
        rf = 0; rc = 0;
      end
      model_refill(3'(rf), rc);
      model_pay(amt);
      pay(4'(amt), 3'(rf), 4'(rc), -1);
      verify($sformatf("rand%0d", t), exp_coins.size(), exp_short, m_cnt[2], m_cnt[1], m_cnt[0]);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
